// File: rtl/aes_mix_columns_seq.sv
// aes_mix_columns_seq
// Column-serial AES MixColumns stage placed after shiftRows. A block is taken
// over a valid/ready handshake, COLS_PER_CYCLE columns are multiplied by the
// {02 03 01 01} circulant matrix over GF(2^8) each clock, and the result is
// offered downstream until accepted. The final round skips the multiply.
module aes_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    // Only 1, 2 and 4 columns per clock divide the four columns evenly.
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter step and the column index that starts the final group.
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [1:0]    col_r;
    logic [127:0]  work_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [127:0]  out_state_r;

    logic [COLS_PER_CYCLE-1:0][1:0]  grp_idx_s;
    logic [COLS_PER_CYCLE-1:0][31:0] grp_out_s;
    logic [127:0]                    work_mixed_s;

    // Multiply by {02} in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        xtime = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One column through the MixColumns matrix; s0 is the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        r0 = xtime(s0) ^ (xtime(s1) ^ s1) ^ s2 ^ s3;
        r1 = s0 ^ xtime(s1) ^ (xtime(s2) ^ s2) ^ s3;
        r2 = s0 ^ s1 ^ xtime(s2) ^ (xtime(s3) ^ s3);
        r3 = (xtime(s0) ^ s0) ^ s1 ^ s2 ^ xtime(s3);
        mix_column = {r0, r1, r2, r3};
    endfunction

    // Extract column idx; column 0 occupies the most significant word.
    function automatic logic [31:0] get_col(input logic [127:0] st, input logic [1:0] idx);
        case (idx)
            2'd0:    get_col = st[127:96];
            2'd1:    get_col = st[95:64];
            2'd2:    get_col = st[63:32];
            2'd3:    get_col = st[31:0];
            default: get_col = 32'h0000_0000;
        endcase
    endfunction

    // Return st with column idx replaced by val.
    function automatic logic [127:0] put_col(input logic [127:0] st, input logic [1:0] idx,
                                             input logic [31:0] val);
        put_col = st;
        case (idx)
            2'd0:    put_col[127:96] = val;
            2'd1:    put_col[95:64]  = val;
            2'd2:    put_col[63:32]  = val;
            2'd3:    put_col[31:0]   = val;
            default: put_col = st;
        endcase
    endfunction

    // Mix the group of columns starting at col_r (one mixer per column lane).
    always_comb begin
        grp_idx_s = '0;
        grp_out_s = '0;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            grp_idx_s[g] = col_r + 2'(g);
            grp_out_s[g] = mix_column(get_col(work_r, grp_idx_s[g]));
        end
    end

    // Merge the freshly mixed group back into the working block.
    always_comb begin
        work_mixed_s = work_r;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_mixed_s = put_col(work_mixed_s, grp_idx_s[g], grp_out_s[g]);
        end
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            col_r       <= 2'd0;
            work_r      <= 128'h0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_state_r <= 128'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_ready_r && in_valid) begin
                        work_r     <= in_state;
                        col_r      <= 2'd0;
                        in_ready_r <= 1'b0;
                        state_r    <= in_bypass ? DONE : BUSY;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    work_r <= work_mixed_s;
                    if (col_r == LAST_COL) begin
                        col_r   <= 2'd0;
                        state_r <= DONE;
                    end else begin
                        col_r <= col_r + COL_STEP;
                    end
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_state_r <= work_r;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    col_r       <= 2'd0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_state = out_state_r;

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Testbench for aes_mix_columns_seq: directed FIPS-197 vectors, latency for
// each column width, bypass, backpressure, mid-block reset, and a randomized
// run scored against a GF(2^8) matrix-multiply reference model.
module tb_aes_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;

    // Shared stimulus for the 2- and 4-column instances.
    logic         x_in_valid;
    logic [127:0] x_in_state;
    logic         x_in_bypass;
    logic         x_out_ready;
    logic         x2_in_ready;
    logic         x2_out_valid;
    logic [127:0] x2_out_state;
    logic         x4_in_ready;
    logic         x4_out_valid;
    logic [127:0] x4_out_state;

    int checks   = 0;
    int failures = 0;

    aes_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_bypass(in_bypass), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state)
    );

    aes_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x2_in_ready),
        .in_state(x_in_state), .in_bypass(x_in_bypass), .out_valid(x2_out_valid),
        .out_ready(x_out_ready), .out_state(x2_out_state)
    );

    aes_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x4_in_ready),
        .in_state(x_in_state), .in_bypass(x_in_bypass), .out_valid(x4_out_valid),
        .out_ready(x_out_ready), .out_state(x4_out_state)
    );

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       carry;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            carry = aa[7];
            aa    = {aa[6:0], 1'b0};
            if (carry) aa = aa ^ 8'h1b;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Reference: out[r] = sum_j M[r][j]*s[j], M row r = {02 03 01 01} rotated right by r.
    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic byp);
        logic [127:0] r;
        logic [7:0]   acc;
        logic [7:0]   coef;
        int           k;
        if (byp) return s;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    k    = (j - row + 4) % 4;
                    coef = (k == 0) ? 8'h02 : ((k == 1) ? 8'h03 : 8'h01);
                    acc  = acc ^ gmul(coef, s[127 - 8 * (4 * c + j) -: 8]);
                end
                r[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block on the main DUT and return after its accept edge.
    task automatic send(input logic [127:0] st, input logic byp);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        in_valid  = 1'b1;
        in_state  = st;
        in_bypass = byp;
        step();
        in_valid  = 1'b0;
        in_state  = rand128();
        in_bypass = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid rises (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_state    = 128'h0;
        in_bypass   = 1'b0;
        out_ready   = 1'b0;
        x_in_valid  = 1'b0;
        x_in_state  = 128'h0;
        x_in_bypass = 1'b0;
        x_out_ready = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        end
        checks++;
        if (out_state !== 128'h0) begin
            failures++;
            $display("FAIL reset_state: out_state=%h required 0", out_state);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({in_ready, x2_in_ready, x4_in_ready, out_valid} !== 4'b1110) begin
            failures++;
            $display("FAIL reset_idle: ready(1,2,4)=%b%b%b out_valid=%b required 111 0",
                     in_ready, x2_in_ready, x4_in_ready, out_valid);
        end
    endtask

    task automatic test_fips();
        logic [127:0] st;
        logic [127:0] exp;
        int lat;
        st  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        exp = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        send(st, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL fips_latency: got %0d cycles required 5", lat);
        end
        checks++;
        if (out_state !== exp) begin
            failures++;
            $display("FAIL fips_value: got %h required %h", out_state, exp);
        end
        checks++;
        if (out_state !== ref_mix(st, 1'b0)) begin
            failures++;
            $display("FAIL fips_model: got %h required %h", out_state, ref_mix(st, 1'b0));
        end
        drain();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL fips_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_cpc_variants();
        logic [127:0] st;
        logic [127:0] exp;
        int lat1;
        int lat2;
        int lat4;
        st  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        exp = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
        // CPC=1 on the main instance.
        send(st, 1'b0);
        wait_out(lat1);
        checks++;
        if (lat1 !== 5 || out_state !== exp) begin
            failures++;
            $display("FAIL cpc1: latency=%0d value=%h required 5 %h", lat1, out_state, exp);
        end
        drain();
        // CPC=2 and CPC=4 accept the same block on the same edge.
        checks++;
        if ({x2_in_ready, x4_in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL cpc_ready: ready2=%b ready4=%b required 1 1", x2_in_ready, x4_in_ready);
        end
        x_in_valid = 1'b1;
        x_in_state = st;
        step();
        x_in_valid = 1'b0;
        x_in_state = rand128();
        lat2 = -1;
        lat4 = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (x2_out_valid && lat2 < 0) lat2 = i;
            if (x4_out_valid && lat4 < 0) lat4 = i;
        end
        checks++;
        if (lat2 !== 3 || x2_out_state !== exp) begin
            failures++;
            $display("FAIL cpc2: latency=%0d value=%h required 3 %h", lat2, x2_out_state, exp);
        end
        checks++;
        if (lat4 !== 2 || x4_out_state !== exp) begin
            failures++;
            $display("FAIL cpc4: latency=%0d value=%h required 2 %h", lat4, x4_out_state, exp);
        end
        x_out_ready = 1'b1;
        step();
        x_out_ready = 1'b0;
        checks++;
        if ({x2_out_valid, x4_out_valid, x2_in_ready, x4_in_ready} !== 4'b0011) begin
            failures++;
            $display("FAIL cpc_release: valid2=%b valid4=%b ready2=%b ready4=%b required 0 0 1 1",
                     x2_out_valid, x4_out_valid, x2_in_ready, x4_in_ready);
        end
    endtask

    task automatic test_bypass();
        logic [127:0] st;
        int lat;
        st = 128'h00112233_44556677_8899aabb_ccddeeff;
        send(st, 1'b1);
        wait_out(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL bypass_latency: got %0d cycles required 1", lat);
        end
        checks++;
        if (out_state !== st) begin
            failures++;
            $display("FAIL bypass_value: got %h required %h", out_state, st);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] exp_a;
        int lat;
        int bad;
        a     = rand128();
        b     = rand128();
        exp_a = ref_mix(a, 1'b0);
        send(a, 1'b0);
        wait_out(lat);
        in_valid  = 1'b1;
        in_state  = b;
        in_bypass = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b1 || out_state !== exp_a || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold: %0d unstable cycles, last out_valid=%b in_ready=%b out_state=%h required 1 0 %h",
                     bad, out_valid, in_ready, out_state, exp_a);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        in_state = rand128();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accept: in_ready=%b required 0", in_ready);
        end
        wait_out(lat);
        checks++;
        if (lat !== 5 || out_state !== ref_mix(b, 1'b0)) begin
            failures++;
            $display("FAIL bp_second_value: latency=%0d value=%h required 5 %h",
                     lat, out_state, ref_mix(b, 1'b0));
        end
        drain();
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] st;
        int lat;
        send(rand128(), 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b00 || out_state !== 128'h0) begin
            failures++;
            $display("FAIL midreset_outputs: out_valid=%b in_ready=%b out_state=%h required 0 0 0",
                     out_valid, in_ready, out_state);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || out_state !== 128'h0) begin
            failures++;
            $display("FAIL midreset_idle: out_valid=%b in_ready=%b out_state=%h required 0 1 0",
                     out_valid, in_ready, out_state);
        end
        st = rand128();
        send(st, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 5 || out_state !== ref_mix(st, 1'b0)) begin
            failures++;
            $display("FAIL midreset_next: latency=%0d value=%h required 5 %h",
                     lat, out_state, ref_mix(st, 1'b0));
        end
        drain();
    endtask

    task automatic test_random();
        logic [127:0] q[$];
        logic [127:0] exp;
        int sent;
        int received;
        int cyc;
        logic acc;
        logic hs;
        sent     = 0;
        received = 0;
        cyc      = 0;
        in_valid = 1'b0;
        while (received < 1000 && cyc < 60000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid  = 1'b1;
                in_state  = rand128();
                in_bypass = ($urandom_range(0, 3) == 0);
            end
            out_ready = ($urandom_range(0, 1) == 1);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_extra: unexpected block %h with nothing outstanding", out_state);
                end else begin
                    exp = q.pop_front();
                    if (out_state !== exp) begin
                        failures++;
                        $display("FAIL rand_block%0d: got %h required %h", received, out_state, exp);
                    end
                end
                received++;
            end
            if (acc) begin
                q.push_back(ref_mix(in_state, in_bypass));
                sent++;
            end
            step();
            cyc++;
            if (acc) begin
                in_valid = 1'b0;
                in_state = rand128();
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (received !== 1000 || q.size() !== 0) begin
            failures++;
            $display("FAIL rand_count: received=%0d outstanding=%0d required 1000 0", received, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_cpc_variants();
        test_bypass();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
